alu_sequencer: RTL and testbench

- Multi-cycle controller that drives the 16-bit ALU datapath and consumes its result flags.
- Holds the instruction register and decodes MOV/ALU instructions.
- Sequences register-file reads into the A/B operand registers, issues ALUop, then loads C or the status register, and writes back to the register file.
- Sits between the instruction source (start/load handshake) and the datapath: register file, A/B/C registers, shifter, ALU and status register.

---
 rtl/risc_pkg.sv | 40 ++++
 rtl/alu_sequencer_if.sv | 43 ++++
 rtl/instr_decoder.sv | 40 ++++
 rtl/alu_sequencer.sv | 150 +++++++++++++++
 tb/tb_alu_sequencer.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/risc_pkg.sv
// Shared types and constants for the ALU sequencer and its instruction decoder.
package risc_pkg;

  localparam int unsigned DataWidth    = 16;
  localparam int unsigned RegAddrWidth = 3;

  typedef enum logic [2:0] {
    WAIT,
    DECODE,
    WRITE_IMM,
    GET_A,
    GET_B,
    COMPUTE,
    WRITE_REG
  } state_e;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] AND = 2'b10;
  localparam logic [1:0] NOT = 2'b11;

  // MOV uses the op field as a sub-opcode
  localparam logic [1:0] MOV_SUB_REG = 2'b00;
  localparam logic [1:0] MOV_SUB_IMM = 2'b10;

  localparam int unsigned OpcodeLsb = 13;
  localparam int unsigned OpLsb     = 11;
  localparam int unsigned RnLsb     = 8;
  localparam int unsigned RdLsb     = 5;
  localparam int unsigned ShiftLsb  = 3;
  localparam int unsigned RmLsb     = 0;

  function automatic logic [DataWidth-1:0] sext8(input logic [7:0] imm);
    return {{(DataWidth - 8){imm[7]}}, imm};
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction handshake plus datapath control/flag bundle of the ALU sequencer.
interface alu_sequencer_if;
  import risc_pkg::*;

  logic                    s;
  logic                    load;
  logic [DataWidth-1:0]    in;
  logic                    Z_in;
  logic                    N_in;
  logic                    V_in;
  logic                    w;
  logic [RegAddrWidth-1:0] readnum;
  logic [RegAddrWidth-1:0] writenum;
  logic                    write;
  logic                    vsel;
  logic                    loada;
  logic                    loadb;
  logic                    loadc;
  logic                    loads;
  logic                    asel;
  logic                    bsel;
  logic [1:0]              ALUop;
  logic [1:0]              shift;
  logic [DataWidth-1:0]    sximm8;
  logic                    Z;
  logic                    N;
  logic                    V;

  // Sequencer side
  modport master (
    input  s, load, in, Z_in, N_in, V_in,
    output w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
    output asel, bsel, ALUop, shift, sximm8, Z, N, V
  );

  // Instruction source / datapath side
  modport slave (
    output s, load, in, Z_in, N_in, V_in,
    input  w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
    input  asel, bsel, ALUop, shift, sximm8, Z, N, V
  );

endinterface

// File: rtl/instr_decoder.sv
// Combinational field extraction, sign extension and instruction classification.
module instr_decoder
  import risc_pkg::*;
(
  input  logic [DataWidth-1:0]    i_ir,
  output logic [RegAddrWidth-1:0] o_rn,
  output logic [RegAddrWidth-1:0] o_rd,
  output logic [RegAddrWidth-1:0] o_rm,
  output logic [1:0]              o_op,
  output logic [1:0]              o_shift,
  output logic [DataWidth-1:0]    o_sximm8,
  output logic                    o_is_mov_imm,
  output logic                    o_is_mov_reg,
  output logic                    o_is_two_op,
  output logic                    o_is_cmp,
  output logic                    o_is_mvn,
  output logic                    o_is_illegal
);

  logic [2:0] w_opcode;
  logic       w_is_alu;

  assign w_opcode = i_ir[OpcodeLsb +: 3];
  assign o_op     = i_ir[OpLsb +: 2];
  assign o_rn     = i_ir[RnLsb +: RegAddrWidth];
  assign o_rd     = i_ir[RdLsb +: RegAddrWidth];
  assign o_rm     = i_ir[RmLsb +: RegAddrWidth];
  assign o_shift  = i_ir[ShiftLsb +: 2];
  assign o_sximm8 = sext8(i_ir[7:0]);

  assign w_is_alu     = (w_opcode == OPC_ALU);
  assign o_is_mov_imm = (w_opcode == OPC_MOV) && (o_op == MOV_SUB_IMM);
  assign o_is_mov_reg = (w_opcode == OPC_MOV) && (o_op == MOV_SUB_REG);
  assign o_is_mvn     = w_is_alu && (o_op == NOT);
  assign o_is_cmp     = w_is_alu && (o_op == SUB);
  // Two-operand ALU ops need Rn fetched into A
  assign o_is_two_op  = w_is_alu && ((o_op == ADD) || (o_op == SUB) || (o_op == AND));
  assign o_is_illegal = !(o_is_mov_imm || o_is_mov_reg || o_is_mvn || o_is_two_op);

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle controller: IR, decode, operand fetch, ALU issue, writeback, status flags.
module alu_sequencer
  import risc_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  alu_sequencer_if.master bus
);

  state_e                  r_state;
  state_e                  w_state_next;
  logic [DataWidth-1:0]    r_ir;
  logic                    r_z;
  logic                    r_n;
  logic                    r_v;

  logic [RegAddrWidth-1:0] w_rn;
  logic [RegAddrWidth-1:0] w_rd;
  logic [RegAddrWidth-1:0] w_rm;
  logic [1:0]              w_op;
  logic                    w_is_mov_imm;
  logic                    w_is_mov_reg;
  logic                    w_is_two_op;
  logic                    w_is_cmp;
  logic                    w_is_mvn;
  logic                    w_is_illegal;

  instr_decoder u_instr_decoder (
    .i_ir         (r_ir),
    .o_rn         (w_rn),
    .o_rd         (w_rd),
    .o_rm         (w_rm),
    .o_op         (w_op),
    .o_shift      (bus.shift),
    .o_sximm8     (bus.sximm8),
    .o_is_mov_imm (w_is_mov_imm),
    .o_is_mov_reg (w_is_mov_reg),
    .o_is_two_op  (w_is_two_op),
    .o_is_cmp     (w_is_cmp),
    .o_is_mvn     (w_is_mvn),
    .o_is_illegal (w_is_illegal)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= WAIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Instruction register: only loadable while idle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ir <= '0;
    end else if ((r_state == WAIT) && bus.load) begin
      r_ir <= bus.in;
    end
  end

  // Status flags, captured only when CMP issues
  always_ff @(posedge clk) begin
    if (reset) begin
      r_z <= 1'b0;
      r_n <= 1'b0;
      r_v <= 1'b0;
    end else if (bus.loads) begin
      r_z <= bus.Z_in;
      r_n <= bus.N_in;
      r_v <= bus.V_in;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      WAIT: begin
        if (bus.s) w_state_next = DECODE;
      end
      DECODE: begin
        if (w_is_illegal) begin
          w_state_next = WAIT;
        end else if (w_is_mov_imm) begin
          w_state_next = WRITE_IMM;
        end else if (w_is_two_op) begin
          w_state_next = GET_A;
        end else begin
          w_state_next = GET_B;
        end
      end
      WRITE_IMM: w_state_next = WAIT;
      GET_A:     w_state_next = GET_B;
      GET_B:     w_state_next = COMPUTE;
      COMPUTE:   w_state_next = w_is_cmp ? WAIT : WRITE_REG;
      WRITE_REG: w_state_next = WAIT;
      default:   w_state_next = WAIT;
    endcase
  end

  // Moore output decode from state plus IR
  always_comb begin
    bus.w        = 1'b0;
    bus.readnum  = '0;
    bus.writenum = '0;
    bus.write    = 1'b0;
    bus.vsel     = 1'b0;
    bus.loada    = 1'b0;
    bus.loadb    = 1'b0;
    bus.loadc    = 1'b0;
    bus.loads    = 1'b0;
    bus.asel     = 1'b0;
    bus.ALUop    = ADD;
    case (r_state)
      WAIT: bus.w = 1'b1;
      WRITE_IMM: begin
        bus.writenum = w_rn;
        bus.vsel     = 1'b1;
        bus.write    = 1'b1;
      end
      GET_A: begin
        bus.readnum = w_rn;
        bus.loada   = 1'b1;
      end
      GET_B: begin
        bus.readnum = w_rm;
        bus.loadb   = 1'b1;
      end
      COMPUTE: begin
        // MOV reg and MVN pass B through with A forced to zero
        bus.ALUop = w_is_mov_reg ? ADD : w_op;
        bus.asel  = w_is_mov_reg || w_is_mvn;
        bus.loads = w_is_cmp;
        bus.loadc = !w_is_cmp;
      end
      WRITE_REG: begin
        bus.writenum = w_rd;
        bus.write    = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.bsel = 1'b0;
  assign bus.Z    = r_z;
  assign bus.N    = r_n;
  assign bus.V    = r_v;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
  import risc_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One expected control vector per busy cycle
  typedef struct packed {
    logic       rd_en;
    logic [2:0] rd;
    logic [2:0] wr;
    logic       write;
    logic       vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic [1:0] aluop;
  } step_t;

  step_t       m_q[$];
  logic [15:0] m_ir;
  logic [2:0]  m_flags;

  // Expand an instruction into the cycles it occupies after leaving WAIT
  task automatic push_instr(input logic [15:0] ir);
    logic [2:0] opc = ir[15:13];
    logic [1:0] op  = ir[12:11];
    bit mov_imm = (opc == 3'b110) && (op == 2'b10);
    bit mov_reg = (opc == 3'b110) && (op == 2'b00);
    bit alu     = (opc == 3'b101);
    bit mvn     = alu && (op == 2'b11);
    bit cmp     = alu && (op == 2'b01);
    step_t t;
    t = '0;
    m_q.push_back(t);
    if (mov_imm) begin
      t = '0; t.write = 1; t.wr = ir[10:8]; t.vsel = 1;
      m_q.push_back(t);
    end else if (mov_reg || alu) begin
      if (alu && !mvn) begin
        t = '0; t.loada = 1; t.rd_en = 1; t.rd = ir[10:8];
        m_q.push_back(t);
      end
      t = '0; t.loadb = 1; t.rd_en = 1; t.rd = ir[2:0];
      m_q.push_back(t);
      t = '0; t.aluop = mov_reg ? 2'b00 : op; t.asel = mov_reg || mvn;
      t.loadc = !cmp; t.loads = cmp;
      m_q.push_back(t);
      if (!cmp) begin
        t = '0; t.write = 1; t.wr = ir[7:5];
        m_q.push_back(t);
      end
    end
  endtask

  // Model update on each edge, full output comparison on each falling edge
  initial begin
    step_t e;
    bit    idle;
    m_ir = '0;
    m_flags = '0;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_q.delete();
        m_ir = '0;
        m_flags = '0;
      end else if (m_q.size() == 0) begin
        if (bus.load) m_ir = bus.in;
        if (bus.s) push_instr(m_ir);
      end else begin
        if (m_q[0].loads) m_flags = {bus.Z_in, bus.N_in, bus.V_in};
        void'(m_q.pop_front());
      end
      @(negedge clk);
      idle = (m_q.size() == 0);
      e = idle ? step_t'(0) : m_q[0];
      check("m_w", bus.w, idle);
      check("m_write", bus.write, e.write);
      check("m_loada", bus.loada, e.loada);
      check("m_loadb", bus.loadb, e.loadb);
      check("m_loadc", bus.loadc, e.loadc);
      check("m_loads", bus.loads, e.loads);
      check("m_asel", bus.asel, e.asel);
      check("m_aluop", bus.ALUop, e.aluop);
      check("m_bsel", bus.bsel, 0);
      if (e.rd_en) check("m_readnum", bus.readnum, e.rd);
      if (e.write) begin
        check("m_writenum", bus.writenum, e.wr);
        check("m_vsel", bus.vsel, e.vsel);
      end
      check("m_shift", bus.shift, m_ir[4:3]);
      check("m_sximm8", bus.sximm8, {{8{m_ir[7]}}, m_ir[7:0]});
      check("m_flags", {bus.Z, bus.N, bus.V}, m_flags);
    end
  end

  int         lat, n_write, n_loads, n_loada;
  logic [2:0] wr_num, rd_a, rd_b;
  logic       wr_vsel, c_asel;
  logic [1:0] c_aluop;
  logic [15:0] wr_imm;

  // Issue one instruction with load and s together; optionally inject ignored
  // load/s activity while busy. Records observations for literal checks.
  task automatic run(input logic [15:0] instr, input logic [2:0] znv, input bit noise);
    @(negedge clk);
    bus.in = instr; bus.load = 1; bus.s = 1;
    {bus.Z_in, bus.N_in, bus.V_in} = znv;
    lat = 0; n_write = 0; n_loads = 0; n_loada = 0;
    wr_num = 'x; rd_a = 'x; rd_b = 'x; wr_vsel = 'x; c_asel = 'x; c_aluop = 'x; wr_imm = 'x;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      bus.load = 0; bus.s = 0;
      if (noise && lat <= 3) begin
        bus.load = 1; bus.s = 1; bus.in = 16'hFFFF;
      end
      if (bus.write) begin
        n_write++; wr_num = bus.writenum; wr_vsel = bus.vsel; wr_imm = bus.sximm8;
      end
      if (bus.loada) begin n_loada++; rd_a = bus.readnum; end
      if (bus.loadb) rd_b = bus.readnum;
      if (bus.loadc || bus.loads) begin c_asel = bus.asel; c_aluop = bus.ALUop; end
      if (bus.loads) n_loads++;
    end while (!bus.w && lat < 20);
    if (!bus.w) begin
      checks++; errors++;
      $display("FAIL run_timeout instr=%0h actual_w=0 required_w=1", instr);
    end
  endtask

  initial begin
    logic [6:0] pat;
    bit seen;
    int nw;
    bus.s = 0; bus.load = 0; bus.in = '0;
    bus.Z_in = 0; bus.N_in = 0; bus.V_in = 0;
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    check("rst_w", bus.w, 1);
    check("rst_strobes", {bus.write, bus.loada, bus.loadb, bus.loadc, bus.loads}, 0);
    check("rst_flags", {bus.Z, bus.N, bus.V}, 0);

    // MOV R1, #-10
    run(16'hD1F6, 3'b000, 0);
    check("movi_lat", lat, 3);
    check("movi_nwrite", n_write, 1);
    check("movi_wrnum", wr_num, 1);
    check("movi_vsel", wr_vsel, 1);
    check("movi_imm", wr_imm, 16'hFFF6);

    // ADD R7, R0, R1 with flag inputs active but not loaded
    run(16'hA0E1, 3'b111, 0);
    check("add_lat", lat, 6);
    check("add_rda", rd_a, 0);
    check("add_rdb", rd_b, 1);
    check("add_aluop", c_aluop, 2'b00);
    check("add_wrnum", wr_num, 7);
    check("add_vsel", wr_vsel, 0);
    check("add_flags", {bus.Z, bus.N, bus.V}, 3'b000);

    // CMP R1, R2
    run(16'hA902, 3'b011, 0);
    check("cmp_lat", lat, 5);
    check("cmp_nwrite", n_write, 0);
    check("cmp_nloads", n_loads, 1);
    check("cmp_aluop", c_aluop, 2'b01);
    check("cmp_flags", {bus.Z, bus.N, bus.V}, 3'b011);

    // Flags hold through MOV
    run(16'hD1F6, 3'b100, 0);
    check("hold_flags", {bus.Z, bus.N, bus.V}, 3'b011);

    // MVN R5, R3
    run(16'hB8A3, 3'b000, 0);
    check("mvn_lat", lat, 5);
    check("mvn_noa", n_loada, 0);
    check("mvn_asel", c_asel, 1);
    check("mvn_aluop", c_aluop, 2'b11);
    check("mvn_wrnum", wr_num, 5);

    // MOV R5, R3
    run(16'hC0A3, 3'b000, 0);
    check("movr_lat", lat, 5);
    check("movr_noa", n_loada, 0);
    check("movr_asel", c_asel, 1);
    check("movr_aluop", c_aluop, 2'b00);
    check("movr_wrnum", wr_num, 5);

    // AND R2, R3, R2 with shift 11
    run(16'hB35A, 3'b000, 0);
    check("and_lat", lat, 6);
    check("and_aluop", c_aluop, 2'b10);
    check("and_rda", rd_a, 3);
    check("and_wrnum", wr_num, 2);
    check("and_shift", bus.shift, 2'b11);

    // Undefined encodings return straight to WAIT
    run(16'hE000, 3'b000, 0);
    check("ill1_lat", lat, 2);
    check("ill1_nwrite", n_write, 0);
    run(16'hC800, 3'b000, 0);
    check("ill2_lat", lat, 2);

    // load/s while busy are ignored
    run(16'hA0E1, 3'b000, 1);
    check("noise_lat", lat, 6);
    check("noise_wrnum", wr_num, 7);
    check("noise_ir", bus.sximm8, 16'hFFE1);

    // s held high: back-to-back with one WAIT cycle between
    @(negedge clk);
    bus.in = 16'hD1F6; bus.load = 1; bus.s = 1;
    pat = '0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      @(negedge clk);
      pat = {pat[5:0], bus.w};
    end
    bus.load = 0; bus.s = 0;
    check("b2b_pattern", pat, 7'b0010010);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk);
      @(negedge clk);
      seen = bus.w;
    end
    check("b2b_drain", seen, 1);

    // Reset during GET_B of an ADD
    @(negedge clk);
    bus.in = 16'hA0E1; bus.load = 1; bus.s = 1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk);
      @(negedge clk);
      bus.load = 0; bus.s = 0;
      seen = bus.loadb;
    end
    check("rmid_reach_getb", seen, 1);
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    check("rmid_w", bus.w, 1);
    check("rmid_ir", {bus.sximm8, bus.shift}, 18'h0);
    check("rmid_flags", {bus.Z, bus.N, bus.V}, 3'b000);
    check("rmid_strobes", {bus.write, bus.loadc}, 2'b00);
    nw = 0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.write) nw++;
    end
    check("rmid_nowrite", nw, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
